acc_req_arbiter: RTL
====================

# acc_req_arbiter

Shares one accelerator request/response port between `NumReq` accelerator dispatchers, e.g. several CVA6 harts driving one Ara instance. Requests are granted round-robin with a stable grant under backpressure. Each accepted request's requester index goes into an in-order tag FIFO. Responses, which the accelerator returns in acceptance order, are routed back to the requester at the FIFO head.

## Interface
- `NumReq`, 2: number of requesters, ≥2.
- `ReqW`, 128: width of the opaque request payload (insn, rs1, rs2, trans_id, store_pending, packed by the requester).
- `RespW`, 72: width of the opaque response payload (result, trans_id, error, load/store_complete).
- `Depth`, 4: maximum outstanding accepted-but-unanswered requests; a power of two ≥2.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `req_data_i`  in  NumReq*ReqW  per-requester payload; slice k belongs to requester k.
- `req_valid_i`  in  NumReq  per-requester request valid.
- `req_ready_o`  out  NumReq  per-requester request ready.
- `resp_data_o`  out  RespW  response payload, broadcast to all requesters.
- `resp_valid_o`  out  NumReq  response valid, one-hot to the owning requester.
- `resp_ready_i`  in  NumReq  per-requester response ready.
- `acc_req_data_o`  out  ReqW  selected payload.
- `acc_req_valid_o`  out  1  request valid to the accelerator.
- `acc_req_ready_i`  in  1  accelerator accepts the request.
- `acc_resp_data_i`  in  RespW  accelerator response payload.
- `acc_resp_valid_i`  in  1  accelerator response valid.
- `acc_resp_ready_o`  out  1  response ready to the accelerator.
- `outstanding_o`  out  $clog2(Depth)+1  number of entries in the tag FIFO.
- `orphan_resp_o`  out  1  sticky flag: a response arrived while the tag FIFO was empty.

## Operation
State: round-robin pointer `rr_q` (0..NumReq-1), lock flag plus locked index `lock_q/lock_idx_q`, tag FIFO (Depth entries × $clog2(NumReq) bits, read/write pointers, count), sticky `orphan_q`.

**Arbitration**
- `full` = count==Depth.
- When unlocked, the candidate is the first valid requester scanning k = rr_q, rr_q+1, … mod NumReq.
- When locked, the candidate is `lock_idx_q`.
- `acc_req_valid_o` = candidate exists && !full.
- `acc_req_data_o` = the candidate's slice. It is 0 when there is no candidate.
- `req_ready_o[k]` = (k==candidate) && !full && acc_req_ready_i.
- Lock: if `acc_req_valid_o` && !acc_req_ready_i, set lock_q=1 and lock_idx_q=candidate. Valid and data are then guaranteed stable until the handshake, even if a higher-priority requester arrives.
- On handshake: push the candidate index into the FIFO, clear lock_q, set rr_q = candidate+1 mod NumReq.
- Requesters must not drop valid before ready; the block does not check this.

**Response routing**
- head = FIFO read data; `empty` = count==0.
- `resp_data_o` = acc_resp_data_i, passed through.
- `resp_valid_o[k]` = acc_resp_valid_i && !empty && head==k.
- `acc_resp_ready_o` = empty ? 1 : resp_ready_i[head].
- A handshake with !empty pops the FIFO.
- A response while empty is consumed and dropped (ready=1, all resp_valid_o low) and sets `orphan_q`. `orphan_q` clears only on reset.

**Counting**
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- When full, no push happens even if a pop occurs the same cycle. `full` is evaluated on the registered count.

## Timing
- Request path is zero-latency combinational: requester to accelerator, and accelerator ready back to requester ready.
- Response path is zero-latency combinational. There is no registered stage.
- FIFO, pointer, lock and counter updates are visible the cycle after the handshake.
- A request accepted in cycle t can be answered from cycle t+1 at the earliest. A same-cycle response is routed using the pre-push head.
- Reset values: rr_q=0, lock_q=0, FIFO empty, outstanding_o=0, orphan_resp_o=0.
- Reset values of the combinational outputs: acc_req_valid_o=0, resp_valid_o=0, req_ready_o=0, acc_resp_ready_o=1.
- Reset asserted mid-operation discards all outstanding tags. Responses to those tags that arrive later are flagged as orphans.

## Test plan
- **Round-robin:** NumReq=2, both valid every cycle, acc_req_ready_i=1 → grants alternate 0,1,0,1. outstanding_o increments 1 per cycle and saturates at 4. acc_req_valid_o stays low while full.
- **Stable grant:** req 1 valid, ready=0 for 3 cycles, req 0 raises valid in cycle 2 → acc_req_data_o equals req 1's payload all 3 cycles. On ready, req 1 is accepted and rr_q=0. Req 0 is granted the next cycle.
- **Response routing:** accept reqs in order 1,0,1, then return 3 responses → resp_valid_o sequence 2'b10, 2'b01, 2'b10. outstanding_o ends at 0.
- **Response backpressure:** head=0, resp_ready_i[0]=0 for 2 cycles → acc_resp_ready_o=0 and no pop. Raise ready → pop, outstanding_o decrements by 1.
- **Simultaneous push/pop at count=2:** handshakes on both sides in the same cycle → count stays 2 and the routed response goes to the old head. At count=4 with a pop, req_ready_o stays 0 that cycle.
- **Orphan and reset:** response with an empty FIFO → acc_resp_ready_o=1, no resp_valid_o, orphan_resp_o=1 the next cycle. Assert rst_i with 3 outstanding → all state returns to the reset values above.

Source files
------------

// File: rtl/acc_req_arbiter.sv
// rtl/acc_req_arbiter.sv - round-robin sharing of one accelerator port with in-order response routing
module acc_req_arbiter #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned ReqW   = 128,
  parameter int unsigned RespW  = 72,
  parameter int unsigned Depth  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumReq*ReqW-1:0]   req_data_i,
  input  logic [NumReq-1:0]        req_valid_i,
  output logic [NumReq-1:0]        req_ready_o,
  output logic [RespW-1:0]         resp_data_o,
  output logic [NumReq-1:0]        resp_valid_o,
  input  logic [NumReq-1:0]        resp_ready_i,
  output logic [ReqW-1:0]          acc_req_data_o,
  output logic                     acc_req_valid_o,
  input  logic                     acc_req_ready_i,
  input  logic [RespW-1:0]         acc_resp_data_i,
  input  logic                     acc_resp_valid_i,
  output logic                     acc_resp_ready_o,
  output logic [$clog2(Depth):0]   outstanding_o,
  output logic                     orphan_resp_o
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [IdxW-1:0] rr_q;
  logic            lock_q;
  logic [IdxW-1:0] lock_idx_q;
  logic [IdxW-1:0] tag_mem [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  logic            orphan_q;

  logic            cand_vld;
  logic [IdxW-1:0] cand_idx;
  logic [IdxW:0]   scan_idx;
  logic            full, empty;
  logic [IdxW-1:0] head;
  logic            push, pop;

  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);
  assign head  = tag_mem[rptr_q];

  // Scan from the highest offset down so the lowest offset from rr_q wins.
  always_comb begin
    cand_vld = 1'b0;
    cand_idx = '0;
    scan_idx = '0;
    if (lock_q) begin
      cand_vld = 1'b1;
      cand_idx = lock_idx_q;
    end else begin
      for (int i = NumReq - 1; i >= 0; i--) begin
        scan_idx = {1'b0, rr_q} + (IdxW+1)'(i);
        if (scan_idx >= (IdxW+1)'(NumReq))
          scan_idx = scan_idx - (IdxW+1)'(NumReq);
        if (req_valid_i[scan_idx[IdxW-1:0]]) begin
          cand_vld = 1'b1;
          cand_idx = scan_idx[IdxW-1:0];
        end
      end
    end
  end

  assign acc_req_valid_o = cand_vld && !full;
  assign acc_req_data_o  = cand_vld ? req_data_i[cand_idx*ReqW +: ReqW] : '0;
  assign push            = acc_req_valid_o && acc_req_ready_i;

  assign resp_data_o      = acc_resp_data_i;
  assign acc_resp_ready_o = empty ? 1'b1 : resp_ready_i[head];
  assign pop              = acc_resp_valid_i && acc_resp_ready_o && !empty;

  always_comb begin
    req_ready_o  = '0;
    resp_valid_o = '0;
    for (int k = 0; k < NumReq; k++) begin
      req_ready_o[k]  = cand_vld && (cand_idx == IdxW'(k)) && !full && acc_req_ready_i;
      resp_valid_o[k] = acc_resp_valid_i && !empty && (head == IdxW'(k));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      orphan_q   <= 1'b0;
    end else begin
      if (push) begin
        lock_q <= 1'b0;
        rr_q   <= (cand_idx == IdxW'(NumReq - 1)) ? '0 : cand_idx + 1'b1;
        wptr_q <= wptr_q + 1'b1;
      end else if (acc_req_valid_o) begin
        // Hold the grant so payload stays stable under accelerator backpressure.
        lock_q     <= 1'b1;
        lock_idx_q <= cand_idx;
      end
      if (pop)
        rptr_q <= rptr_q + 1'b1;
      if (push && !pop)
        count_q <= count_q + 1'b1;
      else if (pop && !push)
        count_q <= count_q - 1'b1;
      if (acc_resp_valid_i && empty)
        orphan_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push)
      tag_mem[wptr_q] <= cand_idx;
  end

  assign outstanding_o = count_q;
  assign orphan_resp_o = orphan_q;

endmodule
